// File: rtl/seg_display_pkg.sv
// rtl/seg_display_pkg.sv - shared constants, state type and helpers for the seven-segment decoder
package seg_display_pkg;

    localparam int SEG_W  = 7;
    localparam int PROD_W = 7;
    localparam int DIG_W  = 4;

    // Segment order gfedcba, active-high
    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    typedef enum logic {
        ST_HUNT     = 1'b0,
        ST_GOT_TENS = 1'b1
    } state_t;

    // Largest result is 99, which still fits PROD_W bits
    function automatic logic [PROD_W-1:0] combine_digits(input logic [DIG_W-1:0] tens,
                                                         input logic [DIG_W-1:0] units);
        logic [PROD_W-1:0] t;
        logic [PROD_W-1:0] u;
        t = {3'b000, tens};
        u = {3'b000, units};
        return (t * 7'd10) + u;
    endfunction

endpackage

// File: rtl/seg_display_decoder_if.sv
// rtl/seg_display_decoder_if.sv - bundle of display-side and result-side signals
interface seg_display_decoder_if;
    import seg_display_pkg::*;

    logic [SEG_W-1:0]  segments;
    logic              lsb_digit;
    logic [PROD_W-1:0] product;
    logic              valid;
    logic              error;

    modport master (
        output segments,
        output lsb_digit,
        input  product,
        input  valid,
        input  error
    );

    modport slave (
        input  segments,
        input  lsb_digit,
        output product,
        output valid,
        output error
    );

endinterface

// File: rtl/seg_display_decoder_decode.sv
// rtl/seg_display_decoder_decode.sv - combinational segment-pattern to digit decoder
module seg_digit_decode
    import seg_display_pkg::*;
(
    input  logic [SEG_W-1:0] i_pattern,
    output logic [DIG_W-1:0] o_digit,
    output logic             o_legal,
    output logic             o_blank
);

    // Blank reports digit 0 with o_legal low; the caller decides where blank is allowed
    always_comb begin
        o_digit = '0;
        o_legal = 1'b1;
        o_blank = 1'b0;
        case (i_pattern)
            SEG_0:     o_digit = 4'd0;
            SEG_1:     o_digit = 4'd1;
            SEG_2:     o_digit = 4'd2;
            SEG_3:     o_digit = 4'd3;
            SEG_4:     o_digit = 4'd4;
            SEG_5:     o_digit = 4'd5;
            SEG_6:     o_digit = 4'd6;
            SEG_7:     o_digit = 4'd7;
            SEG_8:     o_digit = 4'd8;
            SEG_9:     o_digit = 4'd9;
            SEG_BLANK: begin
                o_legal = 1'b0;
                o_blank = 1'b1;
            end
            default:   o_legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_display_decoder.sv
// rtl/seg_display_decoder.sv - debounces a multiplexed two-digit display and reports tens*10+units
module seg_display_decoder
    import seg_display_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int MAX_VALUE     = 49
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [SEG_W-1:0]  i_segments,
    input  logic              i_lsb_digit,
    output logic [PROD_W-1:0] o_product,
    output logic              o_valid,
    output logic              o_error
);

    localparam logic [3:0] STABLE_CNT = 4'(STABLE_CYCLES);
    localparam logic [7:0] MAX_CMP    = 8'(MAX_VALUE);

    logic [7:0]        r_sample;
    logic [7:0]        r_prev;
    logic              r_loaded;
    logic              r_prev_ok;
    logic [3:0]        r_cnt;
    logic [3:0]        w_cnt_next;
    logic              w_first;
    logic              w_accept;

    state_t            r_state;
    state_t            w_state_next;
    logic [DIG_W-1:0]  r_tens;
    logic [DIG_W-1:0]  w_tens_next;
    logic [PROD_W-1:0] r_product;
    logic [PROD_W-1:0] w_product_next;
    logic              r_valid;
    logic              w_valid_next;
    logic              r_error;
    logic              w_error_next;

    logic [DIG_W-1:0]  w_digit;
    logic              w_legal;
    logic              w_blank;
    logic [PROD_W-1:0] w_value;

    // r_loaded/r_prev_ok keep the reset contents of the sample registers from counting as a real run
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sample  <= '0;
            r_prev    <= '0;
            r_loaded  <= 1'b0;
            r_prev_ok <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sample  <= {i_lsb_digit, i_segments};
            r_prev    <= r_sample;
            r_loaded  <= 1'b1;
            r_prev_ok <= r_loaded;
            r_cnt     <= w_cnt_next;
        end
    end

    // Counter holds the length of the current run of identical samples
    always_comb begin
        w_first = !r_prev_ok || (r_sample != r_prev);
        if (!r_loaded) begin
            w_cnt_next = '0;
        end else if (w_first) begin
            w_cnt_next = 4'd1;
        end else if (r_cnt >= STABLE_CNT) begin
            w_cnt_next = STABLE_CNT;
        end else begin
            w_cnt_next = r_cnt + 4'd1;
        end
        w_accept = r_loaded && (w_cnt_next == STABLE_CNT) && (w_first || (r_cnt != STABLE_CNT));
    end

    seg_digit_decode u_decode (
        .i_pattern (r_sample[SEG_W-1:0]),
        .o_digit   (w_digit),
        .o_legal   (w_legal),
        .o_blank   (w_blank)
    );

    assign w_value = combine_digits(r_tens, w_digit);

    always_comb begin
        w_state_next   = r_state;
        w_tens_next    = r_tens;
        w_product_next = r_product;
        w_valid_next   = 1'b0;
        w_error_next   = 1'b0;
        if (w_accept) begin
            if (!r_sample[7]) begin
                if (w_legal || w_blank) begin
                    w_tens_next  = w_digit;
                    w_state_next = ST_GOT_TENS;
                end else begin
                    w_error_next = 1'b1;
                    w_state_next = ST_HUNT;
                end
            end else if (r_state == ST_GOT_TENS) begin
                w_state_next = ST_HUNT;
                if (!w_legal || ({1'b0, w_value} > MAX_CMP)) begin
                    w_error_next = 1'b1;
                end else begin
                    w_product_next = w_value;
                    w_valid_next   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= ST_HUNT;
            r_tens    <= '0;
            r_product <= '0;
            r_valid   <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_tens    <= w_tens_next;
            r_product <= w_product_next;
            r_valid   <= w_valid_next;
            r_error   <= w_error_next;
        end
    end

    assign o_product = r_product;
    assign o_valid   = r_valid;
    assign o_error   = r_error;

endmodule

// File: tb/tb_seg_display_decoder.sv
// tb/tb_seg_display_decoder.sv - scoreboard bench for seg_display_decoder
module tb_seg_display_decoder;

    logic clk;
    logic rst_n;
    int   cyc;
    int   checks;
    int   failures;

    typedef struct {
        int   kind;
        int   prod;
        int   lat;
        int   start;
    } exp_t;

    typedef struct {
        logic [6:0] tens;
        logic [6:0] units;
        int         kind;
        int         prod;
    } vec_t;

    exp_t sb[$];
    int   last_prod;
    vec_t vecs[11];

    seg_display_decoder_if vif();

    seg_display_decoder #(
        .STABLE_CYCLES (2),
        .MAX_VALUE     (49)
    ) dut (
        .clk         (clk),
        .reset       (rst_n),
        .i_segments  (vif.segments),
        .i_lsb_digit (vif.lsb_digit),
        .o_product   (vif.product),
        .o_valid     (vif.valid),
        .o_error     (vif.error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic push(input int kind, input int prod, input int lat);
        exp_t e;
        e.kind  = kind;
        e.prod  = prod;
        e.lat   = lat;
        e.start = cyc;
        sb.push_back(e);
    endtask

    task automatic drive(input logic l, input logic [6:0] s, input int n);
        vif.lsb_digit = l;
        vif.segments  = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        repeat (3) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
        sb.delete();
    endtask

    // Kind 1 = valid pulse, 2 = error pulse
    always @(negedge clk) begin
        if (vif.valid || vif.error) begin
            check("valid_error_exclusive", int'(vif.valid && vif.error), 0);
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual valid=%0b error=%0b product=%0d required=no pulse",
                         vif.valid, vif.error, vif.product);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_kind", vif.valid ? 1 : 2, e.kind);
                if (e.kind == 1) begin
                    check("product", int'(vif.product), e.prod);
                    last_prod = e.prod;
                end else begin
                    check("product_held", int'(vif.product), last_prod);
                end
                if (e.lat != 0) check("latency", cyc - e.start, e.lat);
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        last_prod = 0;
        vecs[0]  = '{7'h7F, 7'h07, 2, 0};
        vecs[1]  = '{7'h12, 7'h6F, 3, 0};
        vecs[2]  = '{7'h06, 7'h6F, 1, 19};
        vecs[3]  = '{7'h00, 7'h6F, 1, 9};
        vecs[4]  = '{7'h06, 7'h00, 2, 0};
        vecs[5]  = '{7'h66, 7'h6F, 1, 49};
        vecs[6]  = '{7'h6D, 7'h3F, 2, 0};
        vecs[7]  = '{7'h7D, 7'h7D, 2, 0};
        vecs[8]  = '{7'h3F, 7'h07, 1, 7};
        vecs[9]  = '{7'h4F, 7'h4F, 1, 33};
        vecs[10] = '{7'h5B, 7'h12, 2, 0};

        rst_n         = 1'b0;
        vif.lsb_digit = 1'b1;
        vif.segments  = 7'h3F;
        repeat (3) @(posedge clk);
        #1;
        check("reset_product", int'(vif.product), 0);
        check("reset_valid", int'(vif.valid), 0);
        check("reset_error", int'(vif.error), 0);
        rst_n = 1'b1;
        drive(1'b1, 7'h3F, 4);

        // 4 then 2 -> 42, valid three edges after the units pattern is applied
        drive(1'b0, 7'h66, 4);
        push(1, 42, 3);
        drive(1'b1, 7'h5B, 4);
        wait_drain("seq_42");

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].kind == 3) push(2, 0, 0);
            drive(1'b0, vecs[i].tens, 4);
            if (vecs[i].kind == 1 || vecs[i].kind == 2) push(vecs[i].kind, vecs[i].prod, 0);
            drive(1'b1, vecs[i].units, 4);
            wait_drain($sformatf("vec_%0d", i));
        end

        // Units seen in HUNT are dropped
        drive(1'b1, 7'h06, 4);
        drive(1'b0, 7'h3F, 4);
        push(1, 0, 0);
        drive(1'b1, 7'h3F, 4);
        wait_drain("units_first_ignored");

        // Tens shown for a single cycle never becomes stable
        drive(1'b0, 7'h66, 1);
        drive(1'b1, 7'h5B, 4);
        wait_drain("short_tens");

        // A second tens digit replaces the first
        drive(1'b0, 7'h06, 4);
        drive(1'b0, 7'h5B, 4);
        push(1, 20, 0);
        drive(1'b1, 7'h3F, 4);
        wait_drain("tens_overwrite");

        // Reset between tens and units discards the captured tens
        drive(1'b0, 7'h4F, 4);
        rst_n         = 1'b0;
        vif.lsb_digit = 1'b1;
        vif.segments  = 7'h7D;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        last_prod = 0;
        check("product_after_reset", int'(vif.product), 0);
        drive(1'b1, 7'h7D, 4);
        wait_drain("reset_mid_capture");
        drive(1'b0, 7'h06, 4);
        push(1, 16, 0);
        drive(1'b1, 7'h7D, 4);
        wait_drain("after_reset_16");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
